// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_unit
//  Brief    : Request/response ALU. Arithmetic and logic ops finish in one
//             execute cycle; shifts/rotates iterate one bit per cycle.
//             Flag slots: Z=0, C=1, V=2, N=3.
//             Op codes 0..14 are legal; any other code reports resp_err.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
   parameter int DATA_WIDTH  = 8,
   parameter int FLAGS_WIDTH = 4,
   parameter int OP_WIDTH    = 4
) (
   input  logic                   master_clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [OP_WIDTH-1:0]    req_op,
   input  logic [DATA_WIDTH-1:0]  req_a,
   input  logic [DATA_WIDTH-1:0]  req_b,
   input  logic [FLAGS_WIDTH-1:0] req_flags,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_WIDTH-1:0]  resp_data,
   output logic [FLAGS_WIDTH-1:0] resp_flags,
   output logic                   resp_err
);

   // Flag slot positions inside the processor flag vector
   localparam int PF_Z = 0;
   localparam int PF_C = 1;
   localparam int PF_V = 2;
   localparam int PF_N = 3;
   localparam int MSB  = DATA_WIDTH - 1;

   // Operation codes
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_ADC  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_SBC  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_CMP  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_ORR  = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_LSL  = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_LSR  = OP_WIDTH'(9);
   localparam logic [OP_WIDTH-1:0] OP_ASR  = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] OP_ROL  = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] OP_ROR  = OP_WIDTH'(12);
   localparam logic [OP_WIDTH-1:0] OP_ROLC = OP_WIDTH'(13);
   localparam logic [OP_WIDTH-1:0] OP_RORC = OP_WIDTH'(14);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  data_q,  data_d;
   logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
   logic                   err_q,   err_d;
   logic [OP_WIDTH-1:0]    op_q,    op_d;
   logic [3:0]             cnt_q,   cnt_d;

   logic [DATA_WIDTH-1:0]  bop_w;
   logic                   cin_w;
   logic [DATA_WIDTH:0]    sum_w;
   logic [DATA_WIDTH-1:0]  exec_data_w;
   logic [FLAGS_WIDTH-1:0] exec_flags_w;
   logic                   exec_err_w;
   logic                   shift_op_w;
   logic                   is_arith_w;
   logic                   is_logic_w;
   logic [DATA_WIDTH-1:0]  step_data_w;
   logic                   step_c_w;

   // Outputs decode straight from registered state
   assign req_ready  = reset_n && (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_data  = data_q;
   assign resp_flags = flags_q;
   assign resp_err   = err_q;

   // Shared adder: subtraction is A + ~B + carry-in (C=1 means no borrow)
   always_comb begin
      bop_w = req_b;
      cin_w = 1'b0;
      case (req_op)
         OP_ADC:         cin_w = req_flags[PF_C];
         OP_SUB, OP_CMP: begin bop_w = ~req_b; cin_w = 1'b1;             end
         OP_SBC:         begin bop_w = ~req_b; cin_w = req_flags[PF_C];  end
         default:        ;
      endcase
      sum_w = {1'b0, req_a} + {1'b0, bop_w} + {{DATA_WIDTH{1'b0}}, cin_w};
   end

   // Single-cycle result and flags for arithmetic, logic and illegal ops
   always_comb begin
      exec_data_w  = req_a;
      exec_flags_w = req_flags;
      exec_err_w   = 1'b0;
      shift_op_w   = 1'b0;
      is_arith_w   = 1'b0;
      is_logic_w   = 1'b0;
      case (req_op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            exec_data_w = sum_w[MSB:0];
            is_arith_w  = 1'b1;
         end
         OP_CMP: is_arith_w = 1'b1;
         OP_AND: begin exec_data_w = req_a & req_b; is_logic_w = 1'b1; end
         OP_ORR: begin exec_data_w = req_a | req_b; is_logic_w = 1'b1; end
         OP_XOR: begin exec_data_w = req_a ^ req_b; is_logic_w = 1'b1; end
         OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_ROLC, OP_RORC:
            shift_op_w = 1'b1;
         default: exec_err_w = 1'b1;
      endcase
      if (is_arith_w) begin
         exec_flags_w[PF_C] = sum_w[DATA_WIDTH];
         exec_flags_w[PF_V] = (req_a[MSB] == bop_w[MSB]) && (sum_w[MSB] != req_a[MSB]);
         exec_flags_w[PF_Z] = (sum_w[MSB:0] == '0);
         exec_flags_w[PF_N] = sum_w[MSB];
      end
      if (is_logic_w) begin
         exec_flags_w[PF_Z] = (exec_data_w == '0);
         exec_flags_w[PF_N] = exec_data_w[MSB];
      end
   end

   // One bit position of the latched shift/rotate op
   always_comb begin
      step_data_w = data_q;
      step_c_w    = flags_q[PF_C];
      case (op_q)
         OP_LSL:  begin step_c_w = data_q[MSB]; step_data_w = {data_q[MSB-1:0], 1'b0};          end
         OP_LSR:  begin step_c_w = data_q[0];   step_data_w = {1'b0, data_q[MSB:1]};            end
         OP_ASR:  begin step_c_w = data_q[0];   step_data_w = {data_q[MSB], data_q[MSB:1]};     end
         OP_ROL:  begin step_c_w = data_q[MSB]; step_data_w = {data_q[MSB-1:0], data_q[MSB]};   end
         OP_ROR:  begin step_c_w = data_q[0];   step_data_w = {data_q[0], data_q[MSB:1]};       end
         OP_ROLC: begin step_c_w = data_q[MSB]; step_data_w = {data_q[MSB-1:0], flags_q[PF_C]}; end
         OP_RORC: begin step_c_w = data_q[0];   step_data_w = {flags_q[PF_C], data_q[MSB:1]};   end
         default: ;
      endcase
   end

   // Next-state: accept in IDLE, iterate in SHIFT, hold result in RESP
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      flags_d = flags_q;
      err_d   = err_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d  = req_op;
               err_d = exec_err_w;
               if (shift_op_w) begin
                  data_d  = req_a;
                  flags_d = req_flags;
                  if (req_b[3:0] == 4'd0) begin
                     state_d = ST_RESP;
                  end else begin
                     cnt_d   = req_b[3:0];
                     state_d = ST_SHIFT;
                  end
               end else begin
                  data_d  = exec_data_w;
                  flags_d = exec_flags_w;
                  state_d = ST_RESP;
               end
            end
         end
         ST_SHIFT: begin
            data_d        = step_data_w;
            flags_d[PF_C] = step_c_w;
            cnt_d         = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               flags_d[PF_Z] = (step_data_w == '0);
               flags_d[PF_N] = step_data_w[MSB];
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any transaction in flight
   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
         op_q    <= '0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         flags_q <= flags_d;
         err_q   <= err_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_unit
//  Brief    : Self-checking bench for alu_seq_unit: directed cases, random
//             transactions against a behavioural model, backpressure, reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

   localparam logic [3:0] ADD = 4'd0,  ADC = 4'd1,  SUB = 4'd2,  SBC = 4'd3;
   localparam logic [3:0] CMP = 4'd4,  LAND = 4'd5, LORR = 4'd6, LXOR = 4'd7;
   localparam logic [3:0] LSL = 4'd8,  LSR = 4'd9,  ASR = 4'd10, ROL = 4'd11;
   localparam logic [3:0] ROR = 4'd12, ROLC = 4'd13, RORC = 4'd14;

   logic       master_clk = 1'b0;
   logic       reset_n    = 1'b0;
   logic       req_valid  = 1'b0;
   logic       resp_ready = 1'b0;
   logic [3:0] req_op     = 4'd0;
   logic [7:0] req_a      = 8'd0;
   logic [7:0] req_b      = 8'd0;
   logic [3:0] req_flags  = 4'd0;
   logic       req_ready;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic [3:0] resp_flags;
   logic       resp_err;

   alu_seq_unit #(.DATA_WIDTH(8), .FLAGS_WIDTH(4), .OP_WIDTH(4)) dut (
      .master_clk (master_clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_flags  (req_flags),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_flags (resp_flags),
      .resp_err   (resp_err)
   );

   always #5 master_clk = ~master_clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0]  d;
      logic [3:0]  f;   // {N,V,C,Z}
      logic        e;
      logic [31:0] lat;
   } exp_t;

   logic [7:0]  cap_d;
   logic [3:0]  cap_f;
   logic        cap_e;
   int          cap_lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic from the operation definitions
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [3:0] fl);
      exp_t r;
      int ia, ib, sa, sb, s, ss, c, nc, k, val, res;
      r.d = a; r.f = fl; r.e = 1'b0; r.lat = 1;
      ia = a; ib = b;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      c  = fl[1] ? 1 : 0;
      s  = 0; ss = 0;
      case (op)
         ADD, ADC, SUB, SBC, CMP: begin
            case (op)
               ADD:     begin s = ia + ib;           ss = sa + sb;           end
               ADC:     begin s = ia + ib + c;       ss = sa + sb + c;       end
               SBC:     begin s = ia + (255 - ib) + c; ss = sa - sb - (1 - c); end
               default: begin s = ia + (255 - ib) + 1; ss = sa - sb;         end
            endcase
            res    = s % 256;
            r.f[1] = (s > 255);
            r.f[2] = (ss < -128) || (ss > 127);
            r.f[0] = (res == 0);
            r.f[3] = (res >= 128);
            if (op != CMP) r.d = 8'(res);
         end
         LAND, LORR, LXOR: begin
            r.d    = (op == LAND) ? (a & b) : (op == LORR) ? (a | b) : (a ^ b);
            r.f[0] = (r.d == 8'd0);
            r.f[3] = r.d[7];
         end
         LSL, LSR, ASR, ROL, ROR, ROLC, RORC: begin
            k = ib % 16;
            r.lat = k + 1;
            val = ia;
            for (int i = 0; i < k; i++) begin
               case (op)
                  LSL:  begin c = val / 128; val = (val * 2) % 256;                 end
                  LSR:  begin c = val % 2;   val = val / 2;                         end
                  ASR:  begin c = val % 2;   val = val / 2 + ((val >= 128) ? 128 : 0); end
                  ROL:  begin c = val / 128; val = (val * 2) % 256 + c;             end
                  ROR:  begin c = val % 2;   val = val / 2 + c * 128;               end
                  ROLC: begin nc = val / 128; val = (val * 2) % 256 + c; c = nc;    end
                  default: begin nc = val % 2; val = val / 2 + c * 128; c = nc;    end
               endcase
            end
            r.d    = 8'(val);
            r.f[1] = (c != 0);
            if (k > 0) begin
               r.f[0] = (val == 0);
               r.f[3] = (val >= 128);
            end
         end
         default: r.e = 1'b1;
      endcase
      return r;
   endfunction

   // One full transaction: issue, measure latency, hold under backpressure, hand off
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fl, input int hold);
      exp_t ex;
      int   n;
      ex = model(op, a, b, fl);
      @(negedge master_clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_flags = fl; resp_ready = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge master_clk);
         n++;
      end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(posedge master_clk); #1;
      // garbage on the request side while busy must be ignored
      req_op = 4'($urandom_range(0, 15)); req_a = 8'($urandom_range(0, 255));
      req_b = 8'($urandom_range(0, 255)); req_flags = 4'($urandom_range(0, 15));
      cap_lat = 1;
      while (resp_valid !== 1'b1 && cap_lat < 40) begin
         @(posedge master_clk); #1;
         cap_lat++;
      end
      cap_d = resp_data; cap_f = resp_flags; cap_e = resp_err;
      chk("latency", 32'(cap_lat), ex.lat);
      chk("data", 32'(cap_d), 32'(ex.d));
      chk("flags", 32'(cap_f), 32'(ex.f));
      chk("err", 32'(cap_e), 32'(ex.e));
      chk("busy_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge master_clk); #1;
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_data", 32'(resp_data), 32'(ex.d));
         chk("hold_flags", 32'(resp_flags), 32'(ex.f));
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      @(negedge master_clk);
      resp_ready = 1'b1; req_valid = 1'b0;
      @(posedge master_clk); #1;
      chk("handoff_valid", 32'(resp_valid), 32'd0);
      chk("post_ready", 32'(req_ready), 32'd1);
      resp_ready = 1'b0;
   endtask

   int stale;

   initial begin
      // reset state
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_data", 32'(resp_data), 32'd0);
      chk("rst_flags", 32'(resp_flags), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      repeat (2) @(negedge master_clk);
      reset_n = 1'b1;
      @(posedge master_clk); #1;
      chk("idle_ready", 32'(req_ready), 32'd1);

      // directed cases
      run_op(ADD, 8'hFF, 8'h01, 4'b0000, 0);
      chk("tp_add_d", 32'(cap_d), 32'h00);
      chk("tp_add_f", 32'(cap_f), 32'b0011);
      chk("tp_add_lat", 32'(cap_lat), 32'd1);
      run_op(SUB, 8'h80, 8'h01, 4'b0000, 1);
      chk("tp_sub_d", 32'(cap_d), 32'h7F);
      chk("tp_sub_f", 32'(cap_f), 32'b0110);
      run_op(CMP, 8'h05, 8'h05, 4'b0000, 0);
      chk("tp_cmp_d", 32'(cap_d), 32'h05);
      chk("tp_cmp_f", 32'(cap_f), 32'b0011);
      run_op(ROLC, 8'b1000_0001, 8'd1, 4'b0000, 0);
      chk("tp_rolc_d", 32'(cap_d), 32'h02);
      chk("tp_rolc_c", 32'(cap_f[1]), 32'd1);
      chk("tp_rolc_lat", 32'(cap_lat), 32'd2);
      run_op(ASR, 8'h80, 8'd3, 4'b0000, 0);
      chk("tp_asr_d", 32'(cap_d), 32'hF0);
      chk("tp_asr_f", 32'(cap_f), 32'b1000);
      chk("tp_asr_lat", 32'(cap_lat), 32'd4);
      run_op(LSL, 8'h5A, 8'd0, 4'b1111, 0);
      chk("tp_lsl0_d", 32'(cap_d), 32'h5A);
      chk("tp_lsl0_f", 32'(cap_f), 32'b1111);
      chk("tp_lsl0_lat", 32'(cap_lat), 32'd1);
      run_op(4'hF, 8'h3C, 8'h11, 4'b0101, 5);
      chk("tp_ill_err", 32'(cap_e), 32'd1);
      chk("tp_ill_d", 32'(cap_d), 32'h3C);
      run_op(ADC, 8'h7F, 8'h00, 4'b0010, 0);
      run_op(SBC, 8'h00, 8'h00, 4'b0000, 0);
      run_op(RORC, 8'h01, 8'd9, 4'b0000, 0);
      run_op(ROL, 8'h81, 8'd15, 4'b0000, 0);

      // random transactions
      for (int t = 0; t < 80; t++) begin
         run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
      end

      // reset mid-SHIFT drops the transaction
      @(negedge master_clk);
      req_valid = 1'b1; req_op = ROR; req_a = 8'h01; req_b = 8'd8; req_flags = 4'b0000;
      @(posedge master_clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge master_clk);
      @(negedge master_clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_data", 32'(resp_data), 32'd0);
      chk("midrst_flags", 32'(resp_flags), 32'd0);
      chk("midrst_err", 32'(resp_err), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      @(negedge master_clk);
      reset_n = 1'b1;
      @(posedge master_clk); #1;
      chk("postrst_ready", 32'(req_ready), 32'd1);
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         if (resp_valid !== 1'b0) stale++;
         @(posedge master_clk); #1;
      end
      chk("postrst_no_stale", 32'(stale), 32'd0);

      // unit still works after the dropped transaction
      run_op(LXOR, 8'hAA, 8'hAA, 4'b0110, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
